// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with registered read data, full/empty and almost flags.
// Pointers carry an extra wrap bit so full and empty are told apart without a counter.
module sync_fifo #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AF_LEVEL   = DEPTH - 1,
   parameter int AE_LEVEL   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     w_en,
   input  logic                     r_en,
   input  logic [DATA_WIDTH-1:0]    data_in,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     almost_full,
   output logic                     almost_empty,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam logic [ADDR_W:0] AF_L = (ADDR_W + 1)'(AF_LEVEL);
   localparam logic [ADDR_W:0] AE_L = (ADDR_W + 1)'(AE_LEVEL);
   localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_W:0]       wr_ptr;
   logic [ADDR_W:0]       rd_ptr;
   logic                  wr_acc;
   logic                  rd_acc;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
   assign count = wr_ptr - rd_ptr;

   assign almost_full  = (count >= AF_L);
   assign almost_empty = (count <= AE_L);

   // When full, a simultaneous read frees the slot the write lands in.
   assign rd_acc = r_en && !empty;
   assign wr_acc = w_en && (!full || rd_acc);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         data_out  <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= w_en && !wr_acc;
         underflow <= r_en && empty;
         if (wr_acc) begin
            wr_ptr <= wr_ptr + ONE;
         end
         if (rd_acc) begin
            rd_ptr   <= rd_ptr + ONE;
            data_out <= mem[rd_ptr[ADDR_W-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem[wr_ptr[ADDR_W-1:0]] <= data_in;
      end
   end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: vector table plus hand-written
// sequences for wrap-around, full read/write and mid-run reset.
module tb_sync_fifo;

   logic       clk;
   logic       rst;
   logic       w_en;
   logic       r_en;
   logic [7:0] data_in;
   logic [7:0] data_out;
   logic       full;
   logic       empty;
   logic [3:0] count;
   logic       almost_full;
   logic       almost_empty;
   logic       overflow;
   logic       underflow;

   int checks = 0;
   int errors = 0;

   sync_fifo dut (
      .clk          (clk),
      .rst          (rst),
      .w_en         (w_en),
      .r_en         (r_en),
      .data_in      (data_in),
      .data_out     (data_out),
      .full         (full),
      .empty        (empty),
      .count        (count),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       w;
      logic       r;
      logic [7:0] d;
      logic [7:0] dout;
      int         cnt;
      logic       ov;
      logic       un;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic w, logic r, logic [7:0] d,
                               logic [7:0] dout, int cnt,
                               logic ov, logic un);
      vec_t v;
      v.w = w; v.r = r; v.d = d;
      v.dout = dout; v.cnt = cnt;
      v.ov = ov; v.un = un;
      return v;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Flags follow directly from the expected count for DEPTH=8.
   task automatic chk_state(string tag, logic [7:0] dout, int cnt,
                            logic ov, logic un);
      chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
      chk({tag, ".count"}, 32'(count), 32'(cnt));
      chk({tag, ".full"}, 32'(full), 32'(cnt == 8));
      chk({tag, ".empty"}, 32'(empty), 32'(cnt == 0));
      chk({tag, ".almost_full"}, 32'(almost_full), 32'(cnt >= 7));
      chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= 1));
      chk({tag, ".overflow"}, 32'(overflow), 32'(ov));
      chk({tag, ".underflow"}, 32'(underflow), 32'(un));
   endtask

   task automatic step(logic w, logic r, logic [7:0] d);
      w_en = w;
      r_en = r;
      data_in = d;
      @(posedge clk);
      #1;
      w_en = 1'b0;
      r_en = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      w_en = 1'b0;
      r_en = 1'b0;
      data_in = 8'h00;

      // 1: two writes separated by idle, then two reads
      vt.push_back(mk(1, 0, 8'hAA, 8'h00, 1, 0, 0));
      vt.push_back(mk(0, 0, 8'h00, 8'h00, 1, 0, 0));
      vt.push_back(mk(1, 0, 8'hBB, 8'h00, 2, 0, 0));
      vt.push_back(mk(0, 1, 8'h00, 8'hAA, 1, 0, 0));
      vt.push_back(mk(0, 1, 8'h00, 8'hBB, 0, 0, 0));
      // 3: read while empty
      vt.push_back(mk(0, 1, 8'h00, 8'hBB, 0, 0, 1));
      vt.push_back(mk(0, 0, 8'h00, 8'hBB, 0, 0, 0));
      // 2: fill, overflow, drain
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(1, 0, 8'(i), 8'hBB, i + 1, 0, 0));
      vt.push_back(mk(1, 0, 8'hFF, 8'hBB, 8, 1, 0));
      for (int i = 0; i < 8; i++)
         vt.push_back(mk(0, 1, 8'h00, 8'(i), 7 - i, 0, 0));
      vt.push_back(mk(0, 0, 8'h00, 8'h07, 0, 0, 0));

      #12;
      chk_state("reset", 8'h00, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < vt.size(); i++) begin
         step(vt[i].w, vt[i].r, vt[i].d);
         chk_state($sformatf("vec%0d", i), vt[i].dout, vt[i].cnt,
                   vt[i].ov, vt[i].un);
      end

      // 4: streaming across pointer wrap with one entry preloaded
      step(1, 0, 8'h10);
      chk_state("pre", 8'h07, 1, 0, 0);
      for (int i = 0; i < 20; i++) begin
         step(1, 1, 8'(8'h20 + i));
         chk_state($sformatf("strm%0d", i),
                   (i == 0) ? 8'h10 : 8'(8'h20 + i - 1), 1, 0, 0);
      end
      step(0, 1, 8'h00);
      chk_state("strm_end", 8'h33, 0, 0, 0);

      // 5: simultaneous read/write while full
      for (int i = 0; i < 8; i++)
         step(1, 0, 8'(8'h30 + i));
      chk_state("fill5", 8'h33, 8, 0, 0);
      step(1, 1, 8'h5A);
      chk("full_rw.data_out", 32'(data_out), 32'h30);
      chk("full_rw.count", 32'(count), 32'd8);
      chk("full_rw.full", 32'(full), 32'd1);
      for (int i = 0; i < 7; i++) begin
         step(0, 1, 8'h00);
         chk_state($sformatf("drain%0d", i), 8'(8'h31 + i), 7 - i, 0, 0);
      end
      step(0, 1, 8'h00);
      chk_state("drain_last", 8'h5A, 0, 0, 0);

      // 6: asynchronous reset mid-run discards contents
      for (int i = 0; i < 5; i++)
         step(1, 0, 8'(8'h60 + i));
      chk_state("pre_rst", 8'h5A, 5, 0, 0);
      #3;
      rst = 1'b1;
      #1;
      chk_state("async_rst", 8'h00, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      step(1, 0, 8'h77);
      chk_state("post_w", 8'h00, 1, 0, 0);
      step(0, 1, 8'h00);
      chk_state("post_r", 8'h77, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
